// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: the prediction queue entry,
// the recovery FSM encoding and the sticky error bit positions.
package bru_pkg;

  // One in-flight prediction as recorded at fetch.
  typedef struct packed {
    logic [31:0] pc;
    logic        t_nt;
    logic [31:0] pred_target;
  } bru_entry_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;

  // Sequential next PC of a branch that falls through (wraps modulo 2^32).
  function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-order prediction queue. Occupancy is tracked by read/write pointers
// carrying one extra wrap bit, so full and empty need no separate counter.
// A clear empties the queue and wins over a push in the same cycle.
module pred_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  bru_entry_t wdata,
  output logic       full,
  output logic       empty,
  output bru_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  bru_entry_t  mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values: clear returns to empty, otherwise advance on push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch-time predictions, checks each against the
// real outcome when the branch reaches MEM, and drives redirect, flush and
// predictor-update signals back to fetch.
//
// Handshake: both the fetch push (if_valid & if_is_branch) and the MEM
// resolve (mem_valid & mem_is_branch) are valid-only strobes with no ready.
// The unit never stalls either side; requests it cannot honour (full queue,
// empty queue, or anything during RECOVER) are dropped, and the first two
// are recorded in the sticky err bits.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic             if_is_branch,
  input  logic [31:0]      if_pc,
  input  logic             if_t_nt,
  input  logic [31:0]      if_pred_target,
  input  logic             mem_valid,
  input  logic             mem_is_branch,
  input  logic             mem_taken,
  input  logic [31:0]      mem_target,
  output logic             PCSrc,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             upd_valid,
  output logic             mem_is_taken,
  output logic [31:0]      mem_pc,
  output logic [31:0]      t_addr,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic             q_full,
  output logic [1:0]       err,
  output bru_state_e       dbg_state
);

  // The down-counter only has to hold FLUSH_CYCLES-1.
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0]   FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [FCW-1:0]   FC_ONE     = FCW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  bru_state_e       state_q, state_d;
  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;

  logic             in_recover;
  logic             push_req, res_req;
  logic             resolve, underflow, overflow, mispredict;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  bru_entry_t       head, push_entry;
  logic [31:0]      actual_pc;

  logic             upd_valid_q, upd_valid_d;
  logic             pcsrc_q, pcsrc_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [31:0]      mem_pc_q, mem_pc_d;
  logic             mem_is_taken_q, mem_is_taken_d;
  logic [31:0]      t_addr_q, t_addr_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
  logic [1:0]       err_q, err_d;

  // Request qualification: everything is ignored while recovering.
  assign in_recover = (state_q == RECOVER);
  assign push_req   = if_valid & if_is_branch & ~in_recover;
  assign res_req    = mem_valid & mem_is_branch & ~in_recover;
  assign resolve    = res_req & ~fifo_empty;
  assign underflow  = res_req & fifo_empty;

  // Compare the head prediction with the real outcome.
  assign actual_pc  = mem_taken ? mem_target : fallthrough_pc(head.pc);
  assign mispredict = resolve &
                      ((head.t_nt != mem_taken) |
                       (head.t_nt & mem_taken & (head.pred_target != mem_target)));

  // A mispredict flushes the whole queue, so it neither pops nor accepts the
  // same-cycle push (that push is on the wrong path). A correct resolve frees
  // a slot, letting a push into a full queue through.
  assign fifo_pop   = resolve & ~mispredict;
  assign fifo_push  = push_req & ~mispredict & (~fifo_full | fifo_pop);
  assign overflow   = push_req & ~mispredict & fifo_full & ~fifo_pop;

  assign push_entry = '{pc: if_pc, t_nt: if_t_nt, pred_target: if_pred_target};

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (mispredict),
    .wdata (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Recovery FSM next state: a mispredict opens a FLUSH_CYCLES-long window.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d     = RECOVER;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      RECOVER: begin
        if (flush_cnt_q == '0) state_d     = IDLE;
        else                   flush_cnt_d = flush_cnt_q - FC_ONE;
      end
      default: begin
        state_d     = IDLE;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Recovery FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next values of the update bus, redirect, statistics and sticky errors.
  always_comb begin
    upd_valid_d      = resolve;
    pcsrc_d          = mispredict;
    redirect_pc_d    = redirect_pc_q;
    mem_pc_d         = mem_pc_q;
    mem_is_taken_d   = mem_is_taken_q;
    t_addr_d         = t_addr_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    err_d            = err_q;

    if (resolve) begin
      mem_pc_d       = head.pc;
      mem_is_taken_d = mem_taken;
      t_addr_d       = mem_target;
      if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + CNT_ONE;
    end
    if (mispredict) begin
      redirect_pc_d = actual_pc;
      if (mispredict_cnt_q != CNT_MAX) mispredict_cnt_d = mispredict_cnt_q + CNT_ONE;
    end
    if (underflow) err_d[ERR_UNDERFLOW] = 1'b1;
    if (overflow)  err_d[ERR_OVERFLOW]  = 1'b1;
  end

  // Output registers; everything returns to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_q      <= 1'b0;
      pcsrc_q          <= 1'b0;
      redirect_pc_q    <= 32'h0;
      mem_pc_q         <= 32'h0;
      mem_is_taken_q   <= 1'b0;
      t_addr_q         <= 32'h0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      err_q            <= 2'b00;
    end else begin
      upd_valid_q      <= upd_valid_d;
      pcsrc_q          <= pcsrc_d;
      redirect_pc_q    <= redirect_pc_d;
      mem_pc_q         <= mem_pc_d;
      mem_is_taken_q   <= mem_is_taken_d;
      t_addr_q         <= t_addr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      err_q            <= err_d;
    end
  end

  assign PCSrc          = pcsrc_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = in_recover;
  assign upd_valid      = upd_valid_q;
  assign mem_is_taken   = mem_is_taken_q;
  assign mem_pc         = mem_pc_q;
  assign t_addr         = t_addr_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
  assign q_full         = fifo_full;
  assign err            = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomised stimulus for branch_resolve_unit. A second
// instance with 2-bit counters shares every input to exercise saturation.
module tb_branch_resolve_unit;
  import bru_pkg::*;

  localparam int DEPTH = 4;
  localparam int FLUSH = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_valid, if_is_branch, if_t_nt;
  logic [31:0] if_pc, if_pred_target;
  logic        mem_valid, mem_is_branch, mem_taken;
  logic [31:0] mem_target;

  logic        PCSrc, flush, upd_valid, mem_is_taken, q_full;
  logic [31:0] redirect_pc, mem_pc, t_addr;
  logic [15:0] branch_cnt, mispredict_cnt;
  logic [1:0]  err;
  bru_state_e  dbg_state;

  logic        PCSrc_b, flush_b, upd_valid_b, mem_is_taken_b, q_full_b;
  logic [31:0] redirect_pc_b, mem_pc_b, t_addr_b;
  logic [1:0]  branch_cnt_b, mispredict_cnt_b;
  logic [1:0]  err_b;
  bru_state_e  dbg_state_b;

  branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_is_branch(if_is_branch), .if_pc(if_pc),
    .if_t_nt(if_t_nt), .if_pred_target(if_pred_target),
    .mem_valid(mem_valid), .mem_is_branch(mem_is_branch),
    .mem_taken(mem_taken), .mem_target(mem_target),
    .PCSrc(PCSrc), .redirect_pc(redirect_pc), .flush(flush),
    .upd_valid(upd_valid), .mem_is_taken(mem_is_taken), .mem_pc(mem_pc),
    .t_addr(t_addr), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt),
    .q_full(q_full), .err(err), .dbg_state(dbg_state)
  );

  branch_resolve_unit #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_is_branch(if_is_branch), .if_pc(if_pc),
    .if_t_nt(if_t_nt), .if_pred_target(if_pred_target),
    .mem_valid(mem_valid), .mem_is_branch(mem_is_branch),
    .mem_taken(mem_taken), .mem_target(mem_target),
    .PCSrc(PCSrc_b), .redirect_pc(redirect_pc_b), .flush(flush_b),
    .upd_valid(upd_valid_b), .mem_is_taken(mem_is_taken_b), .mem_pc(mem_pc_b),
    .t_addr(t_addr_b), .branch_cnt(branch_cnt_b), .mispredict_cnt(mispredict_cnt_b),
    .q_full(q_full_b), .err(err_b), .dbg_state(dbg_state_b)
  );

  // ---------------- reference model / scoreboard ----------------
  bru_entry_t   m_q[$];
  logic [97:0]  exp_q[$];   // {mispredict, redirect, pc, taken, target}
  int           m_rec;
  int           m_bcnt, m_mcnt, m_bcnt_b, m_mcnt_b;
  logic [1:0]   m_err;
  int           n_pass  = 0;
  int           n_fail  = 0;
  int           n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_rec    = 0;
    m_bcnt   = 0;
    m_mcnt   = 0;
    m_bcnt_b = 0;
    m_mcnt_b = 0;
    m_err    = 2'b00;
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of stimulus, predicts the result, then checks outputs
  // just after the capturing edge.
  task automatic step(input logic push, input logic [31:0] pc, input logic tnt,
                      input logic [31:0] ptgt, input logic res, input logic taken,
                      input logic [31:0] tgt);
    bru_entry_t  h;
    logic        in_rec, mis, exp_upd;
    logic [31:0] actual;
    logic [97:0] e;
    if_valid = push; if_is_branch = push; if_pc = pc; if_t_nt = tnt; if_pred_target = ptgt;
    mem_valid = res; mem_is_branch = res; mem_taken = taken; mem_target = tgt;

    in_rec  = (m_rec > 0);
    mis     = 1'b0;
    exp_upd = 1'b0;
    if (res && !in_rec) begin
      if (m_q.size() == 0) begin
        m_err[0] = 1'b1;
      end else begin
        h       = m_q.pop_front();
        actual  = taken ? tgt : h.pc + 32'd4;
        mis     = (h.t_nt != taken) || (h.t_nt && taken && (h.pred_target != tgt));
        exp_upd = 1'b1;
        exp_q.push_back({mis, (mis ? actual : 32'h0), h.pc, taken, tgt});
        if (m_bcnt < 65535) m_bcnt++;
        if (m_bcnt_b < 3) m_bcnt_b++;
        if (mis) begin
          if (m_mcnt < 65535) m_mcnt++;
          if (m_mcnt_b < 3) m_mcnt_b++;
          m_q.delete();
        end
      end
    end
    if (push && !in_rec && !mis) begin
      if (m_q.size() < DEPTH) m_q.push_back('{pc: pc, t_nt: tnt, pred_target: ptgt});
      else m_err[1] = 1'b1;
    end
    if (mis) m_rec = FLUSH;
    else if (in_rec) m_rec--;

    @(posedge clk); #1;

    check("upd_valid", 128'(upd_valid), 128'(exp_upd));
    check("pcsrc", 128'(PCSrc), 128'(mis));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (upd_valid === 1'b1)
        check("upd_bus", 128'({PCSrc, (PCSrc ? redirect_pc : 32'h0), mem_pc, mem_is_taken, t_addr}),
              128'(e));
    end
    check("flush", 128'(flush), 128'(m_rec > 0));
    check("state", 128'(dbg_state), 128'((m_rec > 0) ? RECOVER : IDLE));
    check("branch_cnt", 128'(branch_cnt), 128'(m_bcnt));
    check("mispredict_cnt", 128'(mispredict_cnt), 128'(m_mcnt));
    check("branch_cnt_sat", 128'(branch_cnt_b), 128'(m_bcnt_b));
    check("mispredict_cnt_sat", 128'(mispredict_cnt_b), 128'(m_mcnt_b));
    check("q_full", 128'(q_full), 128'(m_q.size() == DEPTH));
    check("err", 128'(err), 128'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic push_nt(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, pc + 32'd4, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic taken, input logic [31:0] tgt);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, taken, tgt);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rpc, rtgt;
    logic        rtnt;
    rst = 1'b1;
    if_valid = 0; if_is_branch = 0; if_pc = 0; if_t_nt = 0; if_pred_target = 0;
    mem_valid = 0; mem_is_branch = 0; mem_taken = 0; mem_target = 0;
    model_reset();

    // Reset state
    #12;
    check("rst_outputs", 128'({PCSrc, flush, upd_valid, mem_is_taken, q_full, err}), 128'(0));
    check("rst_buses", 128'({redirect_pc, mem_pc, t_addr}), 128'(0));
    check("rst_counters", 128'({branch_cnt, mispredict_cnt, branch_cnt_b, mispredict_cnt_b}), 128'(0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Correct not-taken prediction
    push_nt(32'h100);
    resolve(1'b0, 32'h180);
    check("nt_mem_pc", 128'(mem_pc), 128'(32'h100));

    // Direction mispredict with a younger entry behind it
    push_nt(32'h200);
    push_nt(32'h210);
    resolve(1'b1, 32'h400);
    check("dir_redirect", 128'(redirect_pc), 128'(32'h400));
    idle(3);
    // The younger entry was discarded: the next resolve sees the new push.
    push_nt(32'h600);
    resolve(1'b0, 32'h0);
    check("dir_q_cleared", 128'(mem_pc), 128'(32'h600));

    // Target mispredict
    step(1'b1, 32'h280, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 32'h380);
    check("tgt_redirect", 128'(redirect_pc), 128'(32'h380));
    idle(3);
    // Predicted taken, actually not taken
    step(1'b1, 32'h500, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0);
    resolve(1'b0, 32'h700);
    check("nt_redirect", 128'(redirect_pc), 128'(32'h504));
    // Pushes and resolves during recovery are ignored
    step(1'b1, 32'h520, 1'b0, 32'h524, 1'b1, 1'b0, 32'h0);
    idle(2);

    // Full / overflow
    push_nt(32'h1000);
    push_nt(32'h1004);
    push_nt(32'h1008);
    push_nt(32'h100C);
    push_nt(32'h1010);                                          // dropped
    step(1'b1, 32'h1014, 1'b0, 32'h1018, 1'b1, 1'b0, 32'h0);    // push + pop
    check("ovf_err", 128'(err[ERR_OVERFLOW]), 128'(1'b1));
    for (int i = 0; i < DEPTH; i++) resolve(1'b0, 32'h0);
    check("ovf_last_pc", 128'(mem_pc), 128'(32'h1014));

    // Underflow; push with resolve on empty queue is still an underflow
    resolve(1'b0, 32'h0);
    check("unf_err", 128'(err[ERR_UNDERFLOW]), 128'(1'b1));
    step(1'b1, 32'h1100, 1'b0, 32'h1104, 1'b1, 1'b0, 32'h0);
    resolve(1'b0, 32'h0);
    check("unf_push_kept", 128'(mem_pc), 128'(32'h1100));
    check("sat_branch_cnt", 128'(branch_cnt_b), 128'(2'd3));

    // Asynchronous reset in the second flush cycle
    push_nt(32'h800);
    resolve(1'b1, 32'h880);
    mem_valid = 0; mem_is_branch = 0; if_valid = 0; if_is_branch = 0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_flush", 128'(flush), 128'(1'b0));
    check("mid_rst_pcsrc", 128'(PCSrc), 128'(1'b0));
    check("mid_rst_cnt", 128'({branch_cnt, mispredict_cnt}), 128'(0));
    check("mid_rst_qfull", 128'(q_full), 128'(1'b0));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    push_nt(32'h900);
    resolve(1'b0, 32'h0);
    check("post_rst_pc", 128'(mem_pc), 128'(32'h900));

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      rpc  = 32'($urandom_range(0, 1023)) << 2;
      rtnt = 1'($urandom_range(0, 1));
      rtgt = ($urandom_range(0, 1) == 1) ? 32'h2000 : 32'h3000;
      step(1'($urandom_range(0, 1)), rpc, rtnt, (rtnt ? 32'h2000 : rpc + 32'd4),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rtgt);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Back end of the fetch-prediction loop: tracks every branch prediction made at fetch, checks it against the real outcome when the branch reaches MEM, and drives the redirect, flush and predictor-update signals back to the fetch stage. It sits beside the MEM stage. Its update bus feeds the BHT/BTB training inputs (`mem_is_taken`, `mem_pc`, `t_addr`, `PCSrc`). It also provides misprediction statistics.

## Interface
- `DEPTH`, 4 — prediction queue entries (power of 2, ≥2); bounds in-flight branches IF→MEM.
- `FLUSH_CYCLES`, 3 — cycles `flush` stays high after a mispredict (≥1).
- `CNT_W`, 16 — width of statistic counters.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `if_valid` in 1 — fetch stage accepted an instruction this cycle (`PCWrite` high).
- `if_is_branch` in 1 — fetched instruction is a conditional branch.
- `if_pc` in 32 — its PC.
- `if_t_nt` in 1 — predicted taken.
- `if_pred_target` in 32 — next PC chosen by fetch (BTB target or PC+4).
- `mem_valid` in 1 — instruction in MEM is valid this cycle.
- `mem_is_branch` in 1 — it is a conditional branch.
- `mem_taken` in 1 — actual outcome.
- `mem_target` in 32 — computed branch target.
- `PCSrc` out 1 — one-cycle redirect pulse to fetch.
- `redirect_pc` out 32 — correct next PC, valid with `PCSrc`.
- `flush` out 1 — kill IF/ID/EX contents.
- `upd_valid` out 1 — predictor update strobe.
- `mem_is_taken` out 1 — actual outcome for update.
- `mem_pc` out 32 — PC of resolved branch.
- `t_addr` out 32 — actual target for update.
- `branch_cnt` out `CNT_W` — resolved branches.
- `mispredict_cnt` out `CNT_W` — mispredicted branches.
- `q_full` out 1 — queue full.
- `err` out 2 — sticky: [0] underflow, [1] overflow.

## Operation
- **Push.** When `if_valid & if_is_branch`, the block pushes {`if_pc`, `if_t_nt`, `if_pred_target`} into an in-order FIFO.
- **Resolve.** When `mem_valid & mem_is_branch` and the queue is non-empty, the block pops the head entry.
  - Actual next PC = `mem_taken ? mem_target : pc+4` (32-bit add, wrap modulo 2^32).
  - Mispredict = (`t_nt` ≠ `mem_taken`), or (`t_nt` & `mem_taken` & `pred_target` ≠ `mem_target`).
- **Every resolve** updates the following next cycle:
  - `upd_valid`=1 for one cycle.
  - `mem_pc` = entry pc, `mem_is_taken` = `mem_taken`, `t_addr` = `mem_target`.
  - `branch_cnt` += 1.
- **Mispredict.** Additionally:
  - `mispredict_cnt` += 1.
  - `PCSrc`=1 and `redirect_pc` = actual next PC for one cycle.
  - All remaining queue entries are discarded (wrong path); pointers reset to empty.
  - FSM enters RECOVER.
- **FSM.**
  - IDLE → RECOVER on mispredict.
  - RECOVER holds `flush`=1 for `FLUSH_CYCLES` cycles (down-counter), then → IDLE.
  - In RECOVER, pushes and resolves are ignored.
- **Boundary rules.**
  - Resolve with empty queue: no pop, no update, set `err[0]`.
  - Push when full without a simultaneous pop: entry dropped, set `err[1]`.
  - Push when full with a simultaneous pop: accepted.
  - Push in the same cycle as a mispredicting resolve: discarded.
  - Counters saturate at all-ones.
  - A push in the same cycle as a correct resolve on an empty queue is not a resolve (underflow).
- **Reset** (async, any state, including mid-RECOVER):
  - Queue empty, FSM IDLE, counters 0, `err` 0.
  - All outputs 0, including `redirect_pc`, `mem_pc` and `t_addr` = 32'h0.

## Timing
- Resolve in cycle N → `upd_valid`, `PCSrc`, `redirect_pc` and the update bus are registered and valid in cycle N+1 only.
- `flush` is high in cycles N+1 … N+`FLUSH_CYCLES`.
- Counters reflect cycle-N resolves from cycle N+1.
- Push at N is visible to a resolve at N+1 or later; no same-cycle bypass.
- `q_full` is registered, from occupancy == `DEPTH`.
- A mispredict in the last RECOVER cycle cannot occur, because resolves are ignored in RECOVER.

## Structure
- **Package `bru_pkg`:**
  - Queue entry struct {pc[31:0], t_nt, pred_target[31:0]}.
  - FSM enum {IDLE, RECOVER}.
  - `ERR_UNDERFLOW`/`ERR_OVERFLOW` bit indices.
- **Sub-module `pred_fifo`:**
  - Parameterised `DEPTH`, entry-typed.
  - Signals: push, pop, clear, full, empty, head.
  - Occupancy via pointers plus one extra bit.

## Test plan
- **Correct NT:** push pc=0x100, t_nt=0; resolve `mem_taken`=0 → N+1: `upd_valid`=1, `mem_pc`=0x100, `PCSrc`=0, `flush`=0, `branch_cnt`=1.
- **Direction mispredict:** push pc=0x200, t_nt=0, then pc=0x210; resolve `mem_taken`=1, `mem_target`=0x400 →
  - N+1: `PCSrc`=1, `redirect_pc`=0x400.
  - `flush` high 3 cycles; queue empty; `mispredict_cnt`=1.
- **Target mispredict:** t_nt=1, `pred_target`=0x300, actual taken to 0x380 → `redirect_pc`=0x380; predicted NT-wrong taken→not: pc=0x500 → `redirect_pc`=0x504.
- **Full/overflow:** 4 pushes → `q_full`=1; 5th push alone → `err[1]`=1, occupancy 4; push+resolve together → accepted, occupancy stays 4.
- **Underflow & saturation:** resolve on empty → `err[0]`=1, no `upd_valid`; with `CNT_W`=2, 5 resolves → `branch_cnt`=3.
- **Reset mid-RECOVER:** assert `rst` asynchronously in the 2nd flush cycle → `flush`=0, `PCSrc`=0, counters 0 and queue empty immediately; normal push/resolve works after release.
